// File: rtl/serial_chain_ctrl.sv
// serial_chain_ctrl: one-wire host link to N_CHAINS shift-register chains (clk, reset, data_inout, bit_out, update_strobe, busy, err_count)
module serial_chain_ctrl #(
  parameter int DATA_LEN = 8,
  parameter int N_CHAINS = 4,
  parameter int ASCII_LEN = 8,
  parameter logic [ASCII_LEN-1:0] ACK_CHAR = 8'h21,
  parameter logic [ASCII_LEN-1:0] NAK_CHAR = 8'h3F
) (
  input  logic                         clk,
  input  logic                         reset,
  inout  wire                          data_inout,
  output logic [N_CHAINS*DATA_LEN-1:0] bit_out,
  output logic [N_CHAINS-1:0]          update_strobe,
  output logic                         busy,
  output logic [7:0]                   err_count
);
  localparam int CH_BITS = N_CHAINS > 1 ? $clog2(N_CHAINS) : 1;
  localparam int CMD_LEN = 2 + CH_BITS;
  localparam int MAX_A = CMD_LEN > ASCII_LEN ? CMD_LEN : ASCII_LEN;
  localparam int MAX_LEN = MAX_A > DATA_LEN ? MAX_A : DATA_LEN;
  localparam int CNT_W = $clog2(MAX_LEN);
  typedef enum logic [2:0] {IDLE, CMD, TA1, RESP, TA2, WDATA, RDATA} state_t;
  state_t state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [CMD_LEN-1:0] cmd;
  logic [ASCII_LEN-1:0] resp_sr;
  logic [DATA_LEN-1:0] sr [N_CHAINS];
  logic nak, oe, rd_bit;
  logic [1:0] op;
  logic [CH_BITS-1:0] ch;
  logic nak_c;
  assign op = cmd[CMD_LEN-1 -: 2];
  assign ch = cmd[CH_BITS-1:0];
  assign nak_c = {1'b0, ch} >= (CH_BITS+1)'(N_CHAINS);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:         next_state = data_inout ? CMD : IDLE;
      CMD:          next_state = cnt == CNT_W'(CMD_LEN-1) ? TA1 : CMD;
      TA1:          next_state = RESP;
      RESP:         next_state = cnt == CNT_W'(ASCII_LEN-1) ? TA2 : RESP;
      TA2:          next_state = nak || !op[1] ? IDLE : op[0] ? RDATA : WDATA;
      WDATA, RDATA: next_state = cnt == CNT_W'(DATA_LEN-1) ? IDLE : state;
      default:      next_state = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    rd_bit = 1'b0;
    for (int c = 0; c < N_CHAINS; c++)
      if (ch == CH_BITS'(c)) rd_bit = sr[c][DATA_LEN-1];
  end
  assign data_inout = oe ? (state == RDATA ? rd_bit : resp_sr[ASCII_LEN-1]) : 1'bz;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      cmd <= '0;
      resp_sr <= '0;
      nak <= 1'b0;
      oe <= 1'b0;
      bit_out <= '0;
      update_strobe <= '0;
      err_count <= '0;
      for (int c = 0; c < N_CHAINS; c++) sr[c] <= '0;
    end else begin
      cnt <= next_state != state ? '0 : cnt + 1'b1;
      oe <= next_state == RESP || next_state == RDATA;
      update_strobe <= '0;
      if (state == CMD) cmd <= {cmd[CMD_LEN-2:0], data_inout};
      if (state == TA1) begin
        nak <= nak_c;
        resp_sr <= nak_c ? NAK_CHAR : ACK_CHAR;
        if (nak_c && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      if (state == RESP) resp_sr <= resp_sr << 1;
      for (int c = 0; c < N_CHAINS; c++)
        if (!nak && ch == CH_BITS'(c)) begin
          if (state == TA2 && op == 2'b00) sr[c] <= '0;
          if (state == TA2 && op == 2'b01) begin
            bit_out[c*DATA_LEN +: DATA_LEN] <= sr[c];
            update_strobe[c] <= 1'b1;
          end
          if (state == WDATA) sr[c] <= {sr[c][DATA_LEN-2:0], data_inout};
          if (state == RDATA) sr[c] <= {sr[c][DATA_LEN-2:0], sr[c][DATA_LEN-1]};
        end
    end
endmodule

// File: tb/tb_serial_chain_ctrl.sv
// tb_serial_chain_ctrl: randomized frames on a 3-chain controller checked against a chain-level model
module tb_serial_chain_ctrl;
  localparam int DL = 8;
  localparam int NC = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic drv_en = 1'b1;
  logic drv_val = 1'b0;
  wire line;
  logic [NC*DL-1:0] bit_out;
  logic [NC-1:0] update_strobe;
  logic busy;
  logic [7:0] err_count;
  int n_chk = 0;
  int n_err = 0;
  logic [DL-1:0] sr_m [NC];
  logic [DL-1:0] bo_m [NC];
  int err_m = 0;
  assign line = drv_en ? drv_val : 1'bz;
  serial_chain_ctrl #(.DATA_LEN(DL), .N_CHAINS(NC)) dut (
    .clk(clk),
    .reset(reset),
    .data_inout(line),
    .bit_out(bit_out),
    .update_strobe(update_strobe),
    .busy(busy),
    .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [NC*DL-1:0] bo_flat();
    logic [NC*DL-1:0] v;
    for (int c = 0; c < NC; c++) v[c*DL +: DL] = bo_m[c];
    return v;
  endfunction
  task automatic model_reset;
    for (int c = 0; c < NC; c++) begin
      sr_m[c] = '0;
      bo_m[c] = '0;
    end
    err_m = 0;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_oe"}, dut.oe, 0);
    check({tag, "_strobe"}, update_strobe, 0);
    check({tag, "_bit_out"}, bit_out, bo_flat());
    check({tag, "_err"}, err_count, err_m);
  endtask
  task automatic frame(input logic [1:0] op, input logic [1:0] ch, input logic [DL-1:0] data);
    logic nak;
    logic [7:0] chr;
    logic [3:0] cmd;
    nak = ch >= NC;
    chr = nak ? 8'h3F : 8'h21;
    cmd = {op, ch};
    drv_en = 1'b1;
    drv_val = 1'b1;
    step;
    for (int i = 0; i < 4; i++) begin
      drv_val = cmd[3-i];
      check("cmd_busy", busy, 1);
      step;
    end
    drv_en = 1'b0;
    check("ta1_oe", dut.oe, 0);
    step;
    if (nak) err_m = err_m < 255 ? err_m + 1 : 255;
    for (int i = 0; i < 8; i++) begin
      check("resp_oe", dut.oe, 1);
      check("resp_bit", line, chr[7-i]);
      step;
    end
    check("ta2_oe", dut.oe, 0);
    check("ta2_busy", busy, 1);
    step;
    if (!nak)
      case (op)
        2'b00: sr_m[ch] = '0;
        2'b01: begin
          bo_m[ch] = sr_m[ch];
          check("strobe", update_strobe, 32'd1 << ch);
          check("upd_bit_out", bit_out, bo_flat());
          step;
        end
        2'b10: begin
          drv_en = 1'b1;
          for (int i = 0; i < DL; i++) begin
            drv_val = data[DL-1-i];
            check("wr_busy", busy, 1);
            check("wr_oe", dut.oe, 0);
            step;
          end
          sr_m[ch] = data;
        end
        default:
          for (int i = 0; i < DL; i++) begin
            check("rd_oe", dut.oe, 1);
            check("rd_bit", line, sr_m[ch][DL-1-i]);
            step;
          end
      endcase
    drv_en = 1'b1;
    drv_val = 1'b0;
    check_idle("end");
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b1;
    step;
    check_idle("post_reset");
    frame(2'b10, 2'd1, 8'hA5);
    frame(2'b01, 2'd1, 8'h00);
    check("bo_ch1", bit_out[15:8], 8'hA5);
    frame(2'b11, 2'd1, 8'h00);
    frame(2'b11, 2'd1, 8'h00);
    frame(2'b10, 2'd3, 8'h5A);
    frame(2'b00, 2'd1, 8'h00);
    check("bo_ch1_kept", bit_out[15:8], 8'hA5);
    frame(2'b11, 2'd1, 8'h00);
    for (int k = 0; k < 250; k++)
      frame(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom));
    for (int k = 0; k < 256; k++) frame(2'($urandom_range(0, 3)), 2'd3, 8'($urandom));
    check("err_sat", err_count, 8'hFF);
    frame(2'b10, 2'd0, 8'h3C);
    frame(2'b01, 2'd0, 8'h00);
    drv_val = 1'b1;
    step;
    for (int i = 0; i < 4; i++) begin
      drv_val = i[0];
      step;
    end
    drv_en = 1'b0;
    step;
    repeat (3) step;
    check("mid_oe_before", dut.oe, 1);
    #2 reset = 1'b0;
    drv_en = 1'b1;
    drv_val = 1'b0;
    #1;
    model_reset();
    check("mid_oe", dut.oe, 0);
    check("mid_busy", busy, 0);
    check("mid_bit_out", bit_out, 0);
    check("mid_err", err_count, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      step;
      check_idle("hold_low");
    end
    frame(2'b10, 2'd2, 8'hC3);
    frame(2'b11, 2'd2, 8'h00);
    frame(2'b11, 2'd0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/serial_chain_ctrl.md
Name: serial_chain_ctrl

Overview:
- Single-wire, bidirectional serial controller driving several independent daisy-chain shift registers.
- Successor to the single-chain serial controller, generalised to N_CHAINS chains with a channel field in the command and parametrised DATA_LEN.
- Adds behaviour the earlier controller lacks:
  - a real ACK/NAK character response;
  - non-destructive (rotating) readback;
  - a per-chain update strobe;
  - an error counter.
- Sits between the external one-wire host link and the chain output registers.

Parameters:
DATA_LEN, 8, bits per chain
N_CHAINS, 4, number of independent chains (>=1)
ASCII_LEN, 8, response character width
ACK_CHAR, 8'h21, response for valid command ('!')
NAK_CHAR, 8'h3F, response for invalid channel ('?')
(localparams: CH_BITS = max(1,$clog2(N_CHAINS)); CMD_LEN = 2+CH_BITS)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset
data_inout  inout  1  serial line; driven only when internal oe=1, else 'Z
bit_out  output  N_CHAINS*DATA_LEN  parallel output registers, chain c at [c*DATA_LEN +: DATA_LEN]
update_strobe  output  N_CHAINS  one-cycle pulse on chain c when its bit_out is loaded
busy  output  1  high whenever state != IDLE
err_count  output  8  saturating count of NAKed commands

Behaviour:
- Reset (async, reset=0):
  - All shift registers, bit_out, update_strobe, err_count and busy go to 0.
  - oe=0, so data_inout is 'Z; state goes to IDLE.
  - Takes effect mid-operation at any cycle, including while driving. The first start bit is accepted on the first posedge after release.
- Command frame:
  - In IDLE, the first posedge sampling data_inout==1 is the start cycle t0.
  - Bits are sampled MSB first on t0+1..t0+CMD_LEN. cmd[CMD_LEN-1:CMD_LEN-2] is the opcode; cmd[CH_BITS-1:0] is the channel.
  - Opcodes: 00 RESET, 01 UPDATE, 10 WRITE (host->chain), 11 READ (chain->host).
- Turnaround 1 (TA1):
  - Cycle t0+CMD_LEN+1, oe=0.
  - Channel >= N_CHAINS selects NAK_CHAR and increments err_count (saturating at 255). Otherwise ACK_CHAR is selected.
- Response:
  - oe=1 for ASCII_LEN cycles starting t0+CMD_LEN+2; the character is driven MSB first.
- Turnaround 2 (TA2):
  - Next cycle, oe=0.
  - NAK: return to IDLE, no chain changes.
  - RESET: selected chain's shift register cleared at end of TA2. bit_out is not touched.
  - UPDATE: bit_out[chain] <= shift register at end of TA2. update_strobe[chain]=1 for exactly the following cycle.
  - RESET and UPDATE both return to IDLE.
- WRITE: DATA_LEN cycles after TA2. Each cycle the line is sampled and shifted into the selected chain LSB side (sr <= {sr[DATA_LEN-2:0], line}), so the first bit ends up in the MSB. Other chains are unchanged.
- READ: DATA_LEN cycles after TA2, oe=1.
  - Drive sr[DATA_LEN-1] and rotate (sr <= {sr[DATA_LEN-2:0], sr[DATA_LEN-1]}); contents are identical after the frame.
  - oe drops to 0 on the cycle after the last bit.
- After the data phase, the state is IDLE. The start bit is checked starting the following posedge.
- Line sampling in non-IDLE states never triggers a start.
- bit_count is wide enough for max(CMD_LEN, ASCII_LEN, DATA_LEN) and is cleared on every state entry.
- oe is registered, so the line never glitches between states. oe=1 only in Response and READ data cycles.
- update_strobe is 0 except the single UPDATE pulse. busy deasserts in the cycle the state returns to IDLE.

Test Plan:
1. After reset, N_CHAINS=4, DATA_LEN=8: start, cmd 4'b10_01, TA, check '!' = 8'h21 MSB-first on line, TA, send 8'hA5 -> chain1 sr=8'hA5; bit_out all 0, update_strobe 0.
2. Continue: cmd 4'b01_01 -> '!', then update_strobe=4'b0010 for one cycle and bit_out[15:8]=8'hA5, other chains 0.
3. cmd 4'b11_01 -> '!' then line carries 1,0,1,0,0,1,0,1. Repeat read -> same sequence (rotation preserved). oe=0 the cycle after the 8th bit.
4. N_CHAINS=3: cmd 4'b10_11 -> line carries 8'h3F, err_count=1, no data phase, busy low 1 cycle after TA2. 256 such NAKs -> err_count stays 255.
5. cmd 4'b00_01 -> '!', chain1 sr=0 but bit_out[15:8] still 8'hA5. Subsequent read returns 8'h00.
6. Assert reset during the 4th response bit -> data_inout immediately 'Z, busy=0, bit_out=0. Line held 0 after release -> stays IDLE. Next start bit accepted normally.
